// File: rtl/shared_adder_arbiter_pkg.sv
// Shared types and constants for the shared-adder arbiter.
// Requester count, index width, result-register state and pointer reset value.
package shared_adder_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  localparam logic [ID_W-1:0] LAST_RST = 3'd7;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick among 8 requests; search starts just after last.
// Ports: req (8), last (3) in; oh (one-hot), idx (3), any out.
module rr_pick8
  import shared_adder_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] oh,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0]    start;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    off;
  logic               found;

  assign start = last + 3'd1;
  assign dbl   = {req, req};
  // rot[k] is the request k places after start
  assign rot   = dbl[start +: N_REQ];

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        off   = ID_W'(k);
        found = 1'b1;
      end
    end
  end

  assign any = |req;
  assign idx = start + off;
  assign oh  = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/shared_adder_arbiter.sv
// Round-robin sharing of one adder among 8 requesters, registered result.
// Ports: clk, reset (async high), req/req_a/req_b, gnt, rsp_* valid/ready.
module shared_adder_arbiter
  import shared_adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       gnt,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_carry,
  input  logic                   rsp_ready
);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic              pick_any;
  logic              can_accept;
  logic              take;
  logic [WIDTH-1:0]  a_sel, b_sel;
  logic [WIDTH:0]    sum;

  rr_pick8 u_pick (
    .req  (req),
    .last (last),
    .oh   (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // A full register can refill in the same cycle it drains
  assign can_accept = (state == EMPTY) || rsp_ready;
  // Reset masks the grant so the requester stays pending
  assign take       = can_accept && pick_any && !reset;
  assign gnt        = take ? pick_oh : '0;

  assign a_sel = req_a[int'(pick_idx)*WIDTH +: WIDTH];
  assign b_sel = req_b[int'(pick_idx)*WIDTH +: WIDTH];
  assign sum   = {1'b0, a_sel} + {1'b0, b_sel};

  assign rsp_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    if (take) begin
      state_nxt = FULL;
    end else if (rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      last  <= LAST_RST;
    end else begin
      state <= state_nxt;
      if (take) last <= pick_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
    end else if (take) begin
      rsp_id    <= pick_idx;
      rsp_sum   <= sum[WIDTH-1:0];
      rsp_carry <= sum[WIDTH];
    end
  end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Scoreboard bench for shared_adder_arbiter: directed and random traffic.
// A fairness model predicts grants and results; a monitor checks outputs.
module tb_shared_adder_arbiter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     req;
  logic [8*W-1:0] req_a, req_b;
  logic [7:0]     gnt;
  logic           rsp_valid;
  logic [2:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;
  logic           rsp_ready;

  always #5 clk = ~clk;

  shared_adder_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ready (rsp_ready)
  );

  typedef struct packed {
    logic [2:0]   id;
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  logic       m_full   = 1'b0;
  int         m_last   = 7;
  logic [7:0] m_gmask  = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Retire the requesters granted at the edge just passed
  task automatic serve(int n);
    repeat (n) begin
      step();
      req &= ~m_gmask;
    end
  endtask

  // Reference model: fairness rule plus arithmetic, pushes expectations
  always @(negedge clk) begin
    logic [7:0] eg;
    logic [W:0] s;
    int         win;
    eg  = '0;
    win = 0;
    if (reset) begin
      check("gnt_in_reset", 64'(gnt), 64'h0);
      m_full  = 1'b0;
      m_last  = 7;
      m_gmask = '0;
      q.delete();
    end else begin
      check("rsp_valid", 64'(rsp_valid), 64'(m_full));
      if ((!m_full || rsp_ready) && req != 0) begin
        for (int k = 1; k <= 8; k++) begin
          int i;
          i = (m_last + k) % 8;
          if (eg == 0 && req[i]) begin
            eg[i] = 1'b1;
            win   = i;
          end
        end
      end
      check("gnt", 64'(gnt), 64'(eg));
      if (eg != 0) begin
        s = {1'b0, req_a[win*W +: W]} + {1'b0, req_b[win*W +: W]};
        q.push_back('{id: 3'(win), sum: s[W-1:0], carry: s[W]});
        m_full = 1'b1;
        m_last = win;
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end
      m_gmask = eg;
    end
  end

  // Monitor: held result must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: id %0d sum %0h with no expected result", rsp_id, rsp_sum);
      end else begin
        check("rsp_id", 64'(rsp_id), 64'(q[0].id));
        check("rsp_sum", 64'(rsp_sum), 64'(q[0].sum));
        check("rsp_carry", 64'(rsp_carry), 64'(q[0].carry));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b0;
    req       = 8'hFF;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < 8; i++) set_op(i, $urandom, $urandom);
    #2;
    check("rst_valid", 64'(rsp_valid), 64'h0);
    check("rst_id", 64'(rsp_id), 64'h0);
    check("rst_sum", 64'(rsp_sum), 64'h0);
    check("rst_carry", 64'(rsp_carry), 64'h0);
    check("rst_gnt", 64'(gnt), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset     = 1'b0;
    req       = 8'h00;
    rsp_ready = 1'b1;

    // first grant after reset goes to index 0
    step();
    set_op(0, 32'd10, 32'd20);
    req = 8'h01;
    serve(1);

    // single request
    set_op(3, 32'd5, 32'd7);
    req = 8'h08;
    serve(1);

    // park pointer at 7, then full fairness sweep
    req = 8'h80;
    serve(1);
    for (int i = 0; i < 8; i++) set_op(i, $urandom, $urandom);
    req = 8'hFF;
    repeat (9) step();
    req = 8'h00;

    // wrap: pointer 6, then 7 before 0
    set_op(6, 32'd1, 32'd2);
    req = 8'h40;
    serve(1);
    set_op(7, 32'd3, 32'd4);
    set_op(0, 32'd5, 32'd6);
    req = 8'h81;
    serve(2);

    // backpressure while FULL
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, $urandom, $urandom);
    req = 8'h0F;
    repeat (3) step();
    rsp_ready = 1'b1;
    serve(5);

    // carry corners
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
    req = 8'h01;
    serve(1);
    set_op(0, 32'h8000_0000, 32'h8000_0000);
    req = 8'h01;
    serve(1);

    // async reset while FULL with a pending request
    rsp_ready = 1'b0;
    set_op(2, 32'h1234, 32'h4321);
    req = 8'h04;
    serve(1);
    set_op(4, 32'd9, 32'd9);
    req = 8'h10;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(rsp_valid), 64'h0);
    check("async_rst_sum", 64'(rsp_sum), 64'h0);
    check("async_rst_gnt", 64'(gnt), 64'h0);
    @(posedge clk);
    #3;
    reset     = 1'b0;
    rsp_ready = 1'b1;
    set_op(0, 32'd7, 32'd8);
    req = 8'h01;
    serve(1);
    req = 8'h00;

    // random traffic under random backpressure
    repeat (400) begin
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) begin
        if (m_gmask[i]) begin
          if ($urandom_range(0, 1) == 1) set_op(i, rand_op(), rand_op());
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          set_op(i, rand_op(), rand_op());
          req[i] = 1'b1;
        end
      end
    end

    rsp_ready = 1'b1;
    req       = 8'h00;
    repeat (3) step();
    check("queue_empty", 64'(q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
